// File: rtl/multi_word_add_seq.sv
// multi_word_add_seq: word-serial NUM_WORDS*WIDTH add/subtract over one carry-select core,
// least-significant word first, with valid/ready handshakes on both sides.

module Carry_Select_Adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NB = (WIDTH + BLOCK - 1) / BLOCK;
   localparam int PW = NB * BLOCK;
   logic [PW-1:0] ap, bp, sp;
   logic [NB:0]   c;
   logic [PW:0]   full;
   assign ap   = PW'(a);
   assign bp   = PW'(b);
   assign c[0] = cin;
   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [BLOCK:0] r0, r1;
      assign r0 = {1'b0, ap[g*BLOCK +: BLOCK]} + {1'b0, bp[g*BLOCK +: BLOCK]};
      assign r1 = {1'b0, ap[g*BLOCK +: BLOCK]} + {1'b0, bp[g*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
      assign sp[g*BLOCK +: BLOCK] = c[g] ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
      assign c[g+1] = c[g] ? r1[BLOCK] : r0[BLOCK];
   end
   // zero padding of a partial top block leaves the true carry at bit WIDTH
   assign full = {c[NB], sp};
   assign sum  = full[WIDTH-1:0];
   assign cout = full[WIDTH];
endmodule

module multi_word_add_seq #(
   parameter int WIDTH     = 32,
   parameter int NUM_WORDS = 4,
   parameter int BLOCK     = 4,
   localparam int TW       = NUM_WORDS * WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [TW-1:0] a,
   input  logic [TW-1:0] b,
   input  logic          cin,
   input  logic          sub,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [TW-1:0] s,
   output logic          cout,
   output logic          overflow
);
   localparam int IW = $clog2(NUM_WORDS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [TW-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [WIDTH-1:0] core_sum;
   logic             core_cout;
   Carry_Select_Adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) u_core (
      .a    (a_q[idx_q*WIDTH +: WIDTH]),
      .b    (b_q[idx_q*WIDTH +: WIDTH]),
      .cin  (carry_q),
      .sum  (core_sum),
      .cout (core_cout)
   );
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = a;
            b_d     = b ^ {TW{sub}};
            carry_d = cin ^ sub;
         end
         RUN: begin
            s_d[idx_q*WIDTH +: WIDTH] = core_sum;
            carry_d = core_cout;
            idx_d   = idx_q + IW'(1);
            if (idx_q == IW'(NUM_WORDS-1)) begin
               state_d = DONE;
               cout_d  = core_cout;
               ovf_d   = (a_q[TW-1] == b_q[TW-1]) && (core_sum[WIDTH-1] != a_q[TW-1]);
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign s         = s_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_multi_word_add_seq.sv
// tb_multi_word_add_seq: directed vectors with hand-computed results for the 4x32-bit sequencer.

module tb_multi_word_add_seq;
   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
   logic [127:0] a, b, s;
   int           n_checks = 0;
   int           n_fail = 0;
   int           lat;
   logic [127:0] held;
   logic         seen;

   multi_word_add_seq #(.WIDTH(32), .NUM_WORDS(4), .BLOCK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [127:0] ai, input logic [127:0] bi, input logic ci, input logic su,
                     output int l);
      a = ai; b = bi; cin = ci; sub = su; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      l = 0;
      while (!out_valid && l < 20) begin
         tick();
         l++;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_s", s, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);

      op({128{1'b1}}, 128'd1, 1'b0, 1'b0, lat);
      check("ripple_lat", lat, 4);
      check("ripple_s", s, 0);
      check("ripple_cout", cout, 1);
      check("ripple_ovf", overflow, 0);
      tick();
      check("ripple_pulse", out_valid, 0);
      check("ripple_in_ready", in_ready, 1);

      op(128'd5, 128'd7, 1'b0, 1'b1, lat);
      check("sub57_lat", lat, 4);
      check("sub57_s", s, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE);
      check("sub57_cout", cout, 0);
      check("sub57_ovf", overflow, 0);
      tick();
      op(128'd7, 128'd5, 1'b0, 1'b1, lat);
      check("sub75_s", s, 128'd2);
      check("sub75_cout", cout, 1);
      check("sub75_ovf", overflow, 0);
      tick();

      op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, lat);
      check("ovf_add_s", s, {1'b1, 127'd0});
      check("ovf_add_ovf", overflow, 1);
      check("ovf_add_cout", cout, 0);
      tick();
      op({1'b1, 127'd0}, 128'd1, 1'b0, 1'b1, lat);
      check("ovf_sub_s", s, {1'b0, {127{1'b1}}});
      check("ovf_sub_ovf", overflow, 1);
      check("ovf_sub_cout", cout, 1);
      tick();

      op(128'd9, 128'd3, 1'b1, 1'b0, lat);
      check("cin_add_s", s, 128'd13);
      tick();

      out_ready = 1'b0;
      op(128'h00000000_FFFFFFFF_00000000_FFFFFFFF, 128'd1, 1'b0, 1'b0, lat);
      check("bp_lat", lat, 4);
      held = 128'h00000000_FFFFFFFF_00000001_00000000;
      for (int i = 0; i < 10; i++) begin
         check("bp_s", s, held);
         check("bp_valid", out_valid, 1);
         check("bp_cout", cout, 0);
         check("bp_ovf", overflow, 0);
         check("bp_in_ready", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_valid", out_valid, 0);

      a = 128'd10; b = 128'd20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b1; a = 128'd100; b = 128'd200; sub = 1'b1; cin = 1'b1;
      check("busy_in_ready0", in_ready, 0);
      tick();
      a = 128'd555; b = 128'd777;
      check("busy_in_ready1", in_ready, 0);
      tick();
      in_valid = 1'b0;
      lat = 2;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("busy_lat", lat, 4);
      check("busy_s", s, 128'd30);
      check("busy_cout", cout, 0);
      tick();

      a = 128'hFFFF; b = 128'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("midrst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_s", s, 0);
      check("midrst_in_ready_after", in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen |= out_valid;
      end
      check("midrst_no_result", seen, 0);
      op(128'd3, 128'd4, 1'b0, 1'b0, lat);
      check("post_rst_lat", lat, 4);
      check("post_rst_s", s, 128'd7);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
